// File: rtl/c5_alu_seq.sv
// ---------------------------------------------------------------------------
// c5_alu_seq : sequential ALU for the c5 execute stage.
//
// Single-cycle ops (ADD, SUB, SLTU, SLT, OR, AND, XOR, NOR) are computed
// combinationally and registered, so one op per clock can be issued.
// Multi-cycle ops (MULTU, MULT, DIVU, DIV) use an iterative shift-add
// multiplier and a restoring divider. They take WIDTH iterations plus one
// sign-correction cycle.
//
// Build option: define C5_ALU_MULDIV_EN to build the multiplier/divider.
// Without it, opcodes 9-12 behave like undefined codes: single-cycle, result 0.
// Without it, O_busy is tied 0 and O_ready is tied 1.
//
// Ports:
//   I_clk          clock, rising edge
//   I_reset        synchronous reset, active-high
//   I_valid        operation request (accepted when I_valid && O_ready)
//   O_ready        unit can accept an operation this cycle
//   I_a_in/I_b_in  operands A and B (WIDTH bits)
//   I_alu_function opcode (4 bits)
//   O_valid        one-cycle pulse, results valid
//   O_c_alu        result / product low word / quotient
//   O_hi           product high word / remainder, 0 for single-cycle ops
//   O_busy         multi-cycle operation in progress
// ---------------------------------------------------------------------------
module c5_alu_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             I_clk,
   input  logic             I_reset,
   input  logic             I_valid,
   output logic             O_ready,
   input  logic [WIDTH-1:0] I_a_in,
   input  logic [WIDTH-1:0] I_b_in,
   input  logic [3:0]       I_alu_function,
   output logic             O_valid,
   output logic [WIDTH-1:0] O_c_alu,
   output logic [WIDTH-1:0] O_hi,
   output logic             O_busy
);

   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_SLTU = 4'd3;
   localparam logic [3:0] OP_SLT  = 4'd4;
   localparam logic [3:0] OP_OR   = 4'd5;
   localparam logic [3:0] OP_AND  = 4'd6;
   localparam logic [3:0] OP_XOR  = 4'd7;
   localparam logic [3:0] OP_NOR  = 4'd8;

   // Output stage registers
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] c_q, c_d;
   logic [WIDTH-1:0] hi_q, hi_d;

   // Single-cycle result
   logic [WIDTH-1:0] sc_sum;
   logic [WIDTH:0]   sc_diff;
   logic             sc_slt;
   logic [WIDTH-1:0] sc_res;

   // Combinational ALU; the borrow of A-B doubles as the unsigned compare
   always_comb begin
      sc_sum  = I_a_in + I_b_in;
      sc_diff = {1'b0, I_a_in} - {1'b0, I_b_in};
      // Differing signs decide directly; equal signs fall back to the borrow
      sc_slt  = (I_a_in[WIDTH-1] != I_b_in[WIDTH-1]) ? I_a_in[WIDTH-1] : sc_diff[WIDTH];
      sc_res  = '0;
      case (I_alu_function)
         OP_ADD:  sc_res = sc_sum;
         OP_SUB:  sc_res = sc_diff[WIDTH-1:0];
         OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, sc_diff[WIDTH]};
         OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, sc_slt};
         OP_OR:   sc_res = I_a_in | I_b_in;
         OP_AND:  sc_res = I_a_in & I_b_in;
         OP_XOR:  sc_res = I_a_in ^ I_b_in;
         OP_NOR:  sc_res = ~(I_a_in | I_b_in);
         default: sc_res = '0;
      endcase
   end

`ifdef C5_ALU_MULDIV_EN

   localparam logic [3:0] OP_MULTU = 4'd9;
   localparam logic [3:0] OP_MULT  = 4'd10;
   localparam logic [3:0] OP_DIVU  = 4'd11;
   localparam logic [3:0] OP_DIV   = 4'd12;
   localparam int unsigned CNT_W   = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FINISH} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               is_mul_q, is_mul_d;
   logic               neg_q, neg_d;       // negate product / quotient
   logic               rneg_q, rneg_d;     // negate remainder
   logic               div0_q, div0_d;     // divide by zero
   logic [WIDTH-1:0]   mcand_q, mcand_d;   // multiplicand or divisor magnitude
   logic [2*WIDTH-1:0] acc_q, acc_d;       // mul: {hi, lo}; div: {rem, dividend/quotient}
   logic               ready_q, ready_d;
   logic               busy_q, busy_d;

   logic               is_md, is_sgn, a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_r2, div_diff;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] prod_fin;
   logic [WIDTH-1:0]   quo_fin, rem_fin;

   // Operand magnitudes for the signed variants
   always_comb begin
      is_md  = (I_alu_function == OP_MULTU) || (I_alu_function == OP_MULT) ||
               (I_alu_function == OP_DIVU)  || (I_alu_function == OP_DIV);
      is_sgn = (I_alu_function == OP_MULT) || (I_alu_function == OP_DIV);
      a_neg  = is_sgn && I_a_in[WIDTH-1];
      b_neg  = is_sgn && I_b_in[WIDTH-1];
      a_mag  = a_neg ? -I_a_in : I_a_in;
      b_mag  = b_neg ? -I_b_in : I_b_in;
   end

   // One iteration step of each engine, plus final sign correction
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};
      div_r2   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff = div_r2 - {1'b0, mcand_q};
      // Borrow set means the divisor did not fit: restore
      div_next = div_diff[WIDTH] ? {div_r2[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      prod_fin = neg_q ? -acc_q : acc_q;
      quo_fin  = div0_q ? '1 : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
      rem_fin  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   end

   // Next-state and output logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_mul_d = is_mul_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      div0_d   = div0_q;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      valid_d  = 1'b0;
      c_d      = c_q;
      hi_d     = hi_q;

      case (state_q)
         S_IDLE: begin
            if (I_valid) begin
               if (is_md) begin
                  state_d  = S_BUSY;
                  cnt_d    = CNT_W'(WIDTH);
                  is_mul_d = (I_alu_function == OP_MULTU) || (I_alu_function == OP_MULT);
                  div0_d   = !is_mul_d && (I_b_in == '0);
                  // Divide by zero keeps the quotient sign positive
                  neg_d    = (a_neg ^ b_neg) && !div0_d;
                  rneg_d   = a_neg;
                  if (is_mul_d) begin
                     mcand_d = a_mag;
                     acc_d   = {{WIDTH{1'b0}}, b_mag};
                  end else begin
                     mcand_d = b_mag;
                     acc_d   = {{WIDTH{1'b0}}, a_mag};
                  end
               end else begin
                  valid_d = 1'b1;
                  c_d     = sc_res;
                  hi_d    = '0;
               end
            end
         end
         S_BUSY: begin
            acc_d = is_mul_q ? mul_next : div_next;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_FINISH;
            end
         end
         S_FINISH: begin
            valid_d = 1'b1;
            state_d = S_IDLE;
            if (is_mul_q) begin
               c_d  = prod_fin[WIDTH-1:0];
               hi_d = prod_fin[2*WIDTH-1:WIDTH];
            end else begin
               c_d  = quo_fin;
               hi_d = rem_fin;
            end
         end
         default: state_d = S_IDLE;
      endcase

      ready_d = (state_d == S_IDLE);
      busy_d  = (state_d != S_IDLE);
   end

   // State and datapath registers
   always_ff @(posedge I_clk) begin
      if (I_reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         is_mul_q <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         div0_q   <= 1'b0;
         mcand_q  <= '0;
         acc_q    <= '0;
         valid_q  <= 1'b0;
         c_q      <= '0;
         hi_q     <= '0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_mul_q <= is_mul_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         div0_q   <= div0_d;
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         valid_q  <= valid_d;
         c_q      <= c_d;
         hi_q     <= hi_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
      end
   end

   assign O_ready = ready_q;
   assign O_busy  = busy_q;

`else

   // Single-cycle only: every request is accepted and answered next cycle
   always_comb begin
      valid_d = 1'b0;
      c_d     = c_q;
      hi_d    = hi_q;
      if (I_valid) begin
         valid_d = 1'b1;
         c_d     = sc_res;
         hi_d    = '0;
      end
   end

   // Output stage registers
   always_ff @(posedge I_clk) begin
      if (I_reset) begin
         valid_q <= 1'b0;
         c_q     <= '0;
         hi_q    <= '0;
      end else begin
         valid_q <= valid_d;
         c_q     <= c_d;
         hi_q    <= hi_d;
      end
   end

   assign O_ready = 1'b1;
   assign O_busy  = 1'b0;

`endif

   assign O_valid = valid_q;
   assign O_c_alu = c_q;
   assign O_hi    = hi_q;

endmodule

// File: tb/tb_c5_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_c5_alu_seq : directed, table-driven bench for c5_alu_seq (WIDTH=32).
// Multi-cycle checks are built only when C5_ALU_MULDIV_EN is defined;
// otherwise the disabled-feature behaviour of codes 9-12 is checked.
// ---------------------------------------------------------------------------
module tb_c5_alu_seq;

   localparam int unsigned W = 32;

   typedef struct {
      string      name;
      logic [3:0] fn;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_c;
      logic [W-1:0] exp_hi;
      int         exp_lat;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_valid;
   logic         o_ready;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic [3:0]   fn;
   logic         o_valid;
   logic [W-1:0] c_alu;
   logic [W-1:0] hi;
   logic         o_busy;

   int n_pass  = 0;
   int n_total = 0;

   vec_t vecs[$];

   always #5 clk = ~clk;

   c5_alu_seq #(.WIDTH(W)) dut (
      .I_clk          (clk),
      .I_reset        (rst),
      .I_valid        (i_valid),
      .O_ready        (o_ready),
      .I_a_in         (a_in),
      .I_b_in         (b_in),
      .I_alu_function (fn),
      .O_valid        (o_valid),
      .O_c_alu        (c_alu),
      .O_hi           (hi),
      .O_busy         (o_busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Issue one op at the next falling edge, wait for O_valid, check results.
   // While the unit is busy, I_valid is held high with junk to prove it is ignored.
   task automatic do_op(input vec_t v);
      int lat;
      int rdy_low;
      @(negedge clk);
      check({v.name, " ready_at_issue"}, 64'(o_ready), 64'(1));
      i_valid = 1'b1;
      fn      = v.fn;
      a_in    = v.a;
      b_in    = v.b;
      @(posedge clk);
      #1;
      lat     = 0;
      rdy_low = 0;
      while (!o_valid && lat < 100) begin
         if (!o_ready && o_busy) rdy_low++;
         i_valid = 1'b1;
         a_in    = $urandom;
         b_in    = $urandom;
         fn      = 4'($urandom_range(0, 15));
         @(posedge clk);
         #1;
         lat++;
      end
      i_valid = 1'b0;
      check({v.name, " latency"}, 64'(lat), 64'(v.exp_lat));
      check({v.name, " c_alu"}, 64'(c_alu), 64'(v.exp_c));
      check({v.name, " hi"}, 64'(hi), 64'(v.exp_hi));
      if (v.exp_lat > 0) check({v.name, " busy_cycles"}, 64'(rdy_low), 64'(v.exp_lat));
   endtask

   initial begin
      vec_t v;
      int   seen;
      rst     = 1'b1;
      i_valid = 1'b0;
      a_in    = '0;
      b_in    = '0;
      fn      = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      check("reset ready", 64'(o_ready), 64'(1));
      check("reset busy",  64'(o_busy),  64'(0));
      check("reset valid", 64'(o_valid), 64'(0));
      check("reset c_alu", 64'(c_alu),   64'(0));
      check("reset hi",    64'(hi),      64'(0));

      // Single-cycle ops, issued back to back
      vecs.push_back('{"add_wrap", 4'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'h0, 0});
      vecs.push_back('{"sub_neg",  4'd2, 32'd5,         32'd7,         32'hFFFF_FFFE, 32'h0, 0});
      vecs.push_back('{"slt_min",  4'd4, 32'h8000_0000, 32'd1,         32'd1,         32'h0, 0});
      vecs.push_back('{"sltu_min", 4'd3, 32'h8000_0000, 32'd1,         32'd0,         32'h0, 0});
      vecs.push_back('{"nor_zero", 4'd8, 32'd0,         32'd0,         32'hFFFF_FFFF, 32'h0, 0});
      vecs.push_back('{"op14",     4'd14, 32'h1234_5678, 32'h1,        32'd0,         32'h0, 0});
      vecs.push_back('{"or",       4'd5, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 32'h0, 0});
      vecs.push_back('{"and",      4'd6, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 32'h0, 0});
      vecs.push_back('{"xor",      4'd7, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 32'h0, 0});
      vecs.push_back('{"nothing",  4'd0, 32'h1,         32'h2,         32'd0,         32'h0, 0});
      vecs.push_back('{"slt_pos",  4'd4, 32'd5,         32'hFFFF_FFFF, 32'd0,         32'h0, 0});
      vecs.push_back('{"sltu_lt",  4'd3, 32'd1,         32'd2,         32'd1,         32'h0, 0});
      vecs.push_back('{"sub_eq",   4'd2, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0,         32'h0, 0});
`ifdef C5_ALU_MULDIV_EN
      // Multi-cycle ops; each next op is accepted in the previous O_valid cycle
      vecs.push_back('{"mult_neg",   4'd10, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 32'hFFFF_FFFF, 33});
      vecs.push_back('{"multu_max",  4'd9,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 33});
      vecs.push_back('{"mult_negneg",4'd10, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd30,        32'd0,         33});
      vecs.push_back('{"div_neg",    4'd12, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 33});
      vecs.push_back('{"div_negb",   4'd12, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         33});
      vecs.push_back('{"divu_zero",  4'd11, 32'd100,       32'd0,         32'hFFFF_FFFF, 32'd100,       33});
      vecs.push_back('{"div_zero",   4'd12, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB, 33});
      vecs.push_back('{"div_ovf",    4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         33});
      vecs.push_back('{"divu_big",   4'd11, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 32'hF,         33});
      vecs.push_back('{"add_after",  4'd1,  32'd40,        32'd2,         32'd42,        32'd0,         0});
`else
      // Without the mul/div engine, codes 9-12 are single-cycle zeros
      vecs.push_back('{"mult_off",   4'd10, 32'd3,         32'd4,         32'd0,         32'd0,         0});
      vecs.push_back('{"divu_off",   4'd11, 32'd100,       32'd7,         32'd0,         32'd0,         0});
`endif

      foreach (vecs[i]) do_op(vecs[i]);

      // O_valid is a single pulse; results hold afterwards
      @(posedge clk);
      #1;
      check("valid_pulse_drop", 64'(o_valid), 64'(0));
      check("result_hold", 64'(c_alu), 64'(vecs[vecs.size()-1].exp_c));

`ifdef C5_ALU_MULDIV_EN
      // Reset in the middle of a DIVU aborts it without a result
      @(negedge clk);
      i_valid = 1'b1;
      fn      = 4'd11;
      a_in    = 32'd1000;
      b_in    = 32'd3;
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("abort busy_before", 64'(o_busy), 64'(1));
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort ready", 64'(o_ready), 64'(1));
      check("abort busy",  64'(o_busy),  64'(0));
      check("abort valid", 64'(o_valid), 64'(0));
      check("abort c_alu", 64'(c_alu),   64'(0));
      check("abort hi",    64'(hi),      64'(0));
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (o_valid) seen++;
      end
      check("abort no_valid", 64'(seen), 64'(0));
      v = '{"divu_after_rst", 4'd11, 32'd1000, 32'd3, 32'd333, 32'd1, 33};
      do_op(v);
`else
      // Reset clears registered results
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst c_alu", 64'(c_alu),   64'(0));
      check("rst valid", 64'(o_valid), 64'(0));
      check("rst ready", 64'(o_ready), 64'(1));
      seen = 0;
      v = '{"add_after_rst", 4'd1, 32'd40, 32'd2, 32'd42, 32'd0, 0};
      do_op(v);
      check("seen_unused", 64'(seen), 64'(0));
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/c5_alu_seq.md
Name: c5_alu_seq

Overview:
- Parametrised-width sequential ALU for the c5 core.
- Single-cycle ops: the full combinational ALU set (add, subtract, unsigned/signed set-less-than, OR, AND, XOR, NOR) behind a registered output stage with a valid/ready input handshake.
- Multi-cycle ops: an iterative shift-add multiplier and restoring divider, signed and unsigned, returning a double-width product or a quotient/remainder pair.
- Sits in the execute stage. The pipeline stalls on O_ready low.

Parameters:
- WIDTH, 32, datapath width in bits; legal range 8..64.

Ports:
- I_clk  input  1  clock; all state changes on the rising edge.
- I_reset  input  1  synchronous reset, active-high.
- I_valid  input  1  operation request.
- O_ready  output  1  unit can accept an operation this cycle.
- I_a_in  input  WIDTH  operand A.
- I_b_in  input  WIDTH  operand B.
- I_alu_function  input  4  opcode.
- O_valid  output  1  one-cycle pulse: results valid this cycle.
- O_c_alu  output  WIDTH  main result; product low word or quotient.
- O_hi  output  WIDTH  product high word or remainder; 0 for single-cycle ops.
- O_busy  output  1  multi-cycle operation in progress.

Behaviour:
- Opcodes: 0 NOTHING, 1 ADD, 2 SUBTRACT, 3 LESS_THAN (unsigned), 4 LESS_THAN_SIGNED, 5 OR, 6 AND, 7 XOR, 8 NOR, 9 MULTU, 10 MULT, 11 DIVU, 12 DIV.
- Codes 0 and 13-15: treated as single-cycle with result 0.
- Accept rule: accept occurs on an edge where I_valid && O_ready. Operands and opcode are sampled only at accept.
- Reset: state IDLE; O_valid=0, O_c_alu=0, O_hi=0, O_busy=0, O_ready=1 from the first cycle after reset. Reset mid-operation aborts it; no O_valid is produced for the aborted op.
- States: IDLE, BUSY, FINISH.
- O_ready: high only in IDLE.
- O_busy: high in BUSY and FINISH.
- Single-cycle op accepted at edge N:
  - Result is registered at edge N; O_valid is high in cycle N+1.
  - State stays IDLE, so throughput is one op per clock.
- Single-cycle arithmetic: add and subtract wrap modulo 2^WIDTH; no overflow flag.
- LESS_THAN: 1 iff unsigned A<B.
- LESS_THAN_SIGNED: 1 iff two's-complement A<B. Use the sign bits when they differ, otherwise the borrow of A-B.
- Compare results are zero-extended to WIDTH.
- Multi-cycle op accepted at edge N:
  - IDLE->BUSY; iteration counter loaded with WIDTH.
  - For signed ops, operands are converted to magnitudes at accept.
  - Edges N+1..N+WIDTH: one iteration each. BUSY->FINISH on the edge where the counter reaches 0.
  - Edge N+WIDTH+1: sign correction applied, outputs registered, O_valid=1, FINISH->IDLE.
  - O_valid is high in cycle N+WIDTH+2, i.e. latency WIDTH+1 cycles.
  - A new op may be accepted in the same cycle O_valid is high.
- MULT/MULTU: {O_hi,O_c_alu} is the 2*WIDTH-bit product. For MULT, the product is negated iff exactly one operand is negative.
- DIVU/DIV: O_c_alu = quotient, O_hi = remainder.
  - DIV truncates toward zero.
  - DIV remainder takes the sign of the dividend.
- Divide by zero, both DIV and DIVU: quotient all-ones, remainder = A.
- DIV with A = most-negative and B = -1: quotient = most-negative, remainder = 0.
- O_c_alu/O_hi hold their last value after O_valid drops.
- While not IDLE, I_valid is ignored and operands may change freely.

Optional Feature:
- Macro: C5_ALU_MULDIV_EN.
- Defined: multiplier/divider, BUSY/FINISH states and counter are built as described above.
- Undefined: codes 9-12 behave as undefined codes (single-cycle, result 0, O_hi 0). O_busy is tied 0 and O_ready is tied 1.

Test Plan (WIDTH=32):
- Reset, then ADD 0xFFFFFFFF+0x00000002 accepted at edge N -> O_valid cycle N+1, O_c_alu=0x00000001, O_hi=0. Back-to-back SUB 5-7 on the next edge -> 0xFFFFFFFE.
- LESS_THAN_SIGNED A=0x80000000, B=1 -> 1. LESS_THAN with the same operands -> 0. NOR 0,0 -> 0xFFFFFFFF. Opcode 14 -> 0.
- MULT 0xFFFFFFFD (-3) x 7 -> O_ready low for 33 cycles, O_valid exactly 33 cycles after accept, {O_hi,O_c_alu}=0xFFFFFFFF_FFFFFFEB. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE_00000001.
- DIV -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIVU 100/0 -> quotient 0xFFFFFFFF, remainder 100. DIV 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- I_valid held high with changing operands during BUSY -> no extra accept. Next op accepted in the O_valid cycle produces its own correct result.
- I_reset asserted mid-DIVU (iteration 10) -> next cycle O_ready=1, O_busy=0, O_valid never pulses for the aborted op, outputs=0.
- Build without C5_ALU_MULDIV_EN: MULT 3x4 -> O_valid after 1 cycle, O_c_alu=0, O_hi=0.
